// File: rtl/vliw_lsu_arbiter_if.sv
// -----------------------------------------------------------------------------
// vliw_lsu_arbiter_if
// Data-memory request/acknowledge bus between the LSU arbiter and the core's
// external bus logic.
//
// Signals:
//   mem_req    arbiter -> memory  access request, held until mem_ack
//   mem_we     arbiter -> memory  1 = store, 0 = load
//   mem_addr   arbiter -> memory  word-aligned byte address
//   mem_sel    arbiter -> memory  byte-lane enables
//   mem_wdata  arbiter -> memory  store data, replicated into all lanes
//   mem_ack    memory -> arbiter  access complete (rdata valid same cycle)
//   mem_rdata  memory -> arbiter  aligned read word
//
// Modports: master (arbiter side), slave (memory side).
// -----------------------------------------------------------------------------
interface vliw_lsu_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_sel;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_sel, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/vliw_lsu_arbiter.sv
// -----------------------------------------------------------------------------
// vliw_lsu_arbiter
// Shares the single data-memory port between the execution units of one VLIW
// bundle. The load/store requests of an issued bundle are captured, issued one
// at a time in slot order (EU0 first) on the req/ack bus, and load results are
// returned as one-cycle register writebacks. busy stalls the core while any
// captured access is pending or in flight.
//
// Ports:
//   wb_clk_i     system clock (rising edge)
//   rst_n        asynchronous active-low reset
//   issue_valid  bundle strobe; the per-slot fields below are valid this cycle
//   flush        drop every access that has not yet started
//   is_load, is_store, sign_extend   per-slot request/extension flags
//   ls_size      per-slot size (2 bits: 0 byte, 1 half, 2/3 word)
//   ls_addr      per-slot byte address (32 bits, slot0 in the low bits)
//   ls_wdata     per-slot store data (32 bits)
//   ls_dest      per-slot load destination register
//   busy         high while not idle
//   mem          memory bus (vliw_lsu_arbiter_if.master)
//   wb_valid, wb_idx, wb_val         load writeback
//   overrun      sticky: a bundle was issued while busy
//   timeout_err  sticky: an access was abandoned by the ack watchdog
//
// Build option:
//   LSARB_TIMEOUT_EN  when defined, an access that sees no mem_ack for TIMEOUT
//                     consecutive request cycles is abandoned (loads write back
//                     all ones) and timeout_err is set. When undefined the
//                     arbiter waits indefinitely and timeout_err is tied low.
// -----------------------------------------------------------------------------
module vliw_lsu_arbiter #(
    parameter int unsigned NUM_EU    = 3,
    parameter int unsigned REG_IDX_W = 6,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                        wb_clk_i,
    input  logic                        rst_n,
    input  logic                        issue_valid,
    input  logic                        flush,
    input  logic [NUM_EU-1:0]           is_load,
    input  logic [NUM_EU-1:0]           is_store,
    input  logic [NUM_EU-1:0]           sign_extend,
    input  logic [2*NUM_EU-1:0]         ls_size,
    input  logic [32*NUM_EU-1:0]        ls_addr,
    input  logic [32*NUM_EU-1:0]        ls_wdata,
    input  logic [REG_IDX_W*NUM_EU-1:0] ls_dest,
    output logic                        busy,
    vliw_lsu_arbiter_if.master          mem,
    output logic                        wb_valid,
    output logic [REG_IDX_W-1:0]        wb_idx,
    output logic [31:0]                 wb_val,
    output logic                        overrun,
    output logic                        timeout_err
);

    localparam int unsigned SLOT_W = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } state_t;

    // ---------------------------------------------------------------------
    // Lane / data helpers
    // ---------------------------------------------------------------------
    function automatic logic [1:0] lane_of(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return a;
            2'd1:    return {a[1], 1'b0};
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] sel_of(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'd0:    return 4'b0001 << lane;
            2'd1:    return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_of(input logic [1:0] size, input logic [31:0] w);
        case (size)
            2'd0:    return {4{w[7:0]}};
            2'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [1:0] size, input logic [1:0] lane,
                                            input logic sx, input logic [31:0] rd);
        logic [31:0] sh;
        sh = rd >> {lane, 3'b000};
        case (size)
            2'd0:    return {{24{sx & sh[7]}}, sh[7:0]};
            2'd1:    return {{16{sx & sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t                        state_q;
    logic [NUM_EU-1:0]             pend_q;
    logic [NUM_EU-1:0]             load_q;
    logic [NUM_EU-1:0]             sext_q;
    logic [2*NUM_EU-1:0]           size_q;
    logic [32*NUM_EU-1:0]          addr_q;
    logic [32*NUM_EU-1:0]          wdata_q;
    logic [REG_IDX_W*NUM_EU-1:0]   dest_q;
    logic [SLOT_W-1:0]             cur_q;

    logic                          mem_req_q;
    logic                          mem_we_q;
    logic [31:0]                   mem_addr_q;
    logic [3:0]                    mem_sel_q;
    logic [31:0]                   mem_wdata_q;
    logic                          wb_valid_q;
    logic [REG_IDX_W-1:0]          wb_idx_q;
    logic [31:0]                   wb_val_q;
    logic                          overrun_q;

    logic                          tmo_hit;
    logic                          done;

    // ---------------------------------------------------------------------
    // Current (in-flight) slot
    // ---------------------------------------------------------------------
    logic [NUM_EU-1:0]    cur_oh;
    logic [1:0]           cur_size;
    logic [1:0]           cur_lane;
    logic                 cur_sext;
    logic                 cur_load;
    logic [REG_IDX_W-1:0] cur_dest;

    assign cur_oh   = NUM_EU'(1) << cur_q;
    assign cur_size = size_q[2*cur_q +: 2];
    assign cur_lane = lane_of(cur_size, addr_q[32*cur_q +: 2]);
    assign cur_sext = sext_q[cur_q];
    assign cur_load = load_q[cur_q];
    assign cur_dest = dest_q[REG_IDX_W*cur_q +: REG_IDX_W];

    assign done = (state_q == ST_REQ) && (mem.mem_ack || tmo_hit);

    // Pending mask after this cycle's flush/completion. In REQ a flush keeps
    // only the in-flight slot, which itself retires on completion.
    logic [NUM_EU-1:0] pend_gap_d;
    logic [NUM_EU-1:0] pend_req_d;

    always_comb begin
        pend_gap_d = flush ? '0 : pend_q;
        pend_req_d = flush ? (pend_q & cur_oh) : pend_q;
        if (done) begin
            pend_req_d = pend_req_d & ~cur_oh;
        end
    end

    // ---------------------------------------------------------------------
    // Next slot to launch. In IDLE the live bundle inputs are used so that the
    // first request appears the cycle after issue_valid; in GAP the captured
    // copies are used.
    // ---------------------------------------------------------------------
    logic [NUM_EU-1:0]    src_pend;
    logic [NUM_EU-1:0]    src_load;
    logic [2*NUM_EU-1:0]  src_size;
    logic [32*NUM_EU-1:0] src_addr;
    logic [32*NUM_EU-1:0] src_wdata;
    logic [SLOT_W-1:0]    nxt_slot;
    logic                 nxt_any;
    logic [1:0]           nxt_size;
    logic [31:0]          nxt_addr;
    logic [1:0]           nxt_lane;

    always_comb begin
        if (state_q == ST_IDLE) begin
            src_pend  = is_load | is_store;
            src_load  = is_load & ~is_store;
            src_size  = ls_size;
            src_addr  = ls_addr;
            src_wdata = ls_wdata;
        end else begin
            src_pend  = pend_gap_d;
            src_load  = load_q;
            src_size  = size_q;
            src_addr  = addr_q;
            src_wdata = wdata_q;
        end
        nxt_slot = '0;
        for (int unsigned i = NUM_EU; i > 0; i--) begin
            if (src_pend[i-1]) begin
                nxt_slot = SLOT_W'(i - 1);
            end
        end
        nxt_any  = |src_pend;
        nxt_size = src_size[2*nxt_slot +: 2];
        nxt_addr = src_addr[32*nxt_slot +: 32];
        nxt_lane = lane_of(nxt_size, nxt_addr[1:0]);
    end

    // ---------------------------------------------------------------------
    // Control FSM with registered bus and writeback outputs
    // ---------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            load_q      <= '0;
            sext_q      <= '0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            dest_q      <= '0;
            cur_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_sel_q   <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_idx_q    <= '0;
            wb_val_q    <= '0;
            overrun_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;

            if (issue_valid && (state_q != ST_IDLE)) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (issue_valid && !flush) begin
                        pend_q  <= is_load | is_store;
                        load_q  <= is_load & ~is_store;
                        sext_q  <= sign_extend;
                        size_q  <= ls_size;
                        addr_q  <= ls_addr;
                        wdata_q <= ls_wdata;
                        dest_q  <= ls_dest;
                    end
                end
                ST_REQ: begin
                    pend_q <= pend_req_d;
                    if (done) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_GAP;
                        if (cur_load) begin
                            wb_valid_q <= 1'b1;
                            wb_idx_q   <= cur_dest;
                            wb_val_q   <= tmo_hit ? '1
                                                  : extract(cur_size, cur_lane, cur_sext, mem.mem_rdata);
                        end
                    end
                end
                ST_GAP: begin
                    pend_q <= pend_gap_d;
                    if (!nxt_any) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Launch shared by IDLE (fresh bundle) and GAP (next pending slot).
            if (((state_q == ST_IDLE) && issue_valid && !flush) || (state_q == ST_GAP)) begin
                if (nxt_any) begin
                    state_q     <= ST_REQ;
                    cur_q       <= nxt_slot;
                    mem_req_q   <= 1'b1;
                    mem_we_q    <= ~src_load[nxt_slot];
                    mem_addr_q  <= {nxt_addr[31:2], 2'b00};
                    mem_sel_q   <= sel_of(nxt_size, nxt_lane);
                    mem_wdata_q <= wdata_of(nxt_size, src_wdata[32*nxt_slot +: 32]);
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Ack watchdog
    // ---------------------------------------------------------------------
`ifdef LSARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             timeout_err_q;

    assign tmo_hit = (state_q == ST_REQ) && !mem.mem_ack && (tmo_q == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            if ((state_q != ST_REQ) || done) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
            if (tmo_hit) begin
                timeout_err_q <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_timeout;

    assign tmo_hit        = 1'b0;
    assign timeout_err    = 1'b0;
    assign unused_timeout = (TIMEOUT == 0);
`endif

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign busy          = (state_q != ST_IDLE);
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_sel   = mem_sel_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_idx        = wb_idx_q;
    assign wb_val        = wb_val_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_vliw_lsu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vliw_lsu_arbiter
// Directed bench for vliw_lsu_arbiter with hand-computed expected values.
// Inputs change 1 ns after the rising edge; outputs are observed at the same
// point, i.e. after the registers of the preceding edge have settled.
// -----------------------------------------------------------------------------
module tb_vliw_lsu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        issue_valid;
    logic        flush;
    logic [2:0]  is_load;
    logic [2:0]  is_store;
    logic [2:0]  sign_extend;
    logic [5:0]  ls_size;
    logic [95:0] ls_addr;
    logic [95:0] ls_wdata;
    logic [17:0] ls_dest;
    logic        busy;
    logic        wb_valid;
    logic [5:0]  wb_idx;
    logic [31:0] wb_val;
    logic        overrun;
    logic        timeout_err;

    int unsigned n_vec;
    int unsigned n_err;

    vliw_lsu_arbiter_if mem_if ();

    vliw_lsu_arbiter #(
        .NUM_EU   (3),
        .REG_IDX_W(6),
        .TIMEOUT  (255)
    ) dut (
        .wb_clk_i   (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .flush      (flush),
        .is_load    (is_load),
        .is_store   (is_store),
        .sign_extend(sign_extend),
        .ls_size    (ls_size),
        .ls_addr    (ls_addr),
        .ls_wdata   (ls_wdata),
        .ls_dest    (ls_dest),
        .busy       (busy),
        .mem        (mem_if),
        .wb_valid   (wb_valid),
        .wb_idx     (wb_idx),
        .wb_val     (wb_val),
        .overrun    (overrun),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bundle();
        issue_valid = 1'b0;
        flush       = 1'b0;
        is_load     = '0;
        is_store    = '0;
        sign_extend = '0;
        ls_size     = '0;
        ls_addr     = '0;
        ls_wdata    = '0;
        ls_dest     = '0;
    endtask

    task automatic set_slot(input int unsigned s, input logic ld, input logic st, input logic sx,
                            input logic [1:0] sz, input logic [31:0] a, input logic [31:0] w,
                            input logic [5:0] d);
        is_load[s]          = ld;
        is_store[s]         = st;
        sign_extend[s]      = sx;
        ls_size[2*s +: 2]   = sz;
        ls_addr[32*s +: 32] = a;
        ls_wdata[32*s +: 32] = w;
        ls_dest[6*s +: 6]   = d;
    endtask

    // Checks the request currently on the bus, holds it for cyc cycles and
    // acknowledges in the last one. Returns in the cycle after the ack edge.
    task automatic serve(input string tag, input logic [31:0] ea, input logic [3:0] es,
                         input logic ew, input logic [31:0] ed, input int unsigned cyc,
                         input logic [31:0] rd);
        check_eq({tag, ".req"},  {31'd0, mem_if.mem_req}, 32'd1);
        check_eq({tag, ".addr"}, mem_if.mem_addr, ea);
        check_eq({tag, ".sel"},  {28'd0, mem_if.mem_sel}, {28'd0, es});
        check_eq({tag, ".we"},   {31'd0, mem_if.mem_we}, {31'd0, ew});
        if (ew) check_eq({tag, ".wdata"}, mem_if.mem_wdata, ed);
        for (int unsigned k = 1; k < cyc; k++) begin
            tick();
            check_eq({tag, ".hold_req"},  {31'd0, mem_if.mem_req}, 32'd1);
            check_eq({tag, ".hold_addr"}, mem_if.mem_addr, ea);
        end
        mem_if.mem_ack   = 1'b1;
        mem_if.mem_rdata = rd;
        tick();
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;
        check_eq({tag, ".gap_req"}, {31'd0, mem_if.mem_req}, 32'd0);
    endtask

    task automatic check_wb(input string tag, input logic v, input logic [5:0] idx,
                            input logic [31:0] val);
        check_eq({tag, ".wb_valid"}, {31'd0, wb_valid}, {31'd0, v});
        if (v) begin
            check_eq({tag, ".wb_idx"}, {26'd0, wb_idx}, {26'd0, idx});
            check_eq({tag, ".wb_val"}, wb_val, val);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        clear_bundle();
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.busy",     {31'd0, busy}, 32'd0);
        check_eq("rst.req",      {31'd0, mem_if.mem_req}, 32'd0);
        check_eq("rst.we",       {31'd0, mem_if.mem_we}, 32'd0);
        check_eq("rst.addr",     mem_if.mem_addr, 32'd0);
        check_eq("rst.sel",      {28'd0, mem_if.mem_sel}, 32'd0);
        check_eq("rst.wdata",    mem_if.mem_wdata, 32'd0);
        check_eq("rst.wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst.wb_val",   wb_val, 32'd0);
        check_eq("rst.overrun",  {31'd0, overrun}, 32'd0);
        check_eq("rst.tmo",      {31'd0, timeout_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ---- single signed byte load, slot1 @0x103 ----
        set_slot(1, 1'b1, 1'b0, 1'b1, 2'd0, 32'h0000_0103, 32'h0, 6'd17);
        issue_valid = 1'b1;
        tick();
        clear_bundle();
        check_eq("ld1.busy", {31'd0, busy}, 32'd1);
        serve("ld1", 32'h0000_0100, 4'b1000, 1'b0, 32'h0, 2, 32'h8011_2233);
        check_wb("ld1", 1'b1, 6'd17, 32'hFFFF_FF80);
        check_eq("ld1.gap_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("ld1.end_busy", {31'd0, busy}, 32'd0);
        check_wb("ld1.once", 1'b0, 6'd0, 32'h0);

        // ---- three-slot bundle, order 0,1,2 with one-cycle gaps ----
        set_slot(0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF, 6'd0);
        set_slot(1, 1'b1, 1'b0, 1'b0, 2'd1, 32'h0000_0022, 32'h0,         6'd5);
        set_slot(2, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0033, 32'h1234_565A, 6'd0);
        issue_valid = 1'b1;
        tick();
        clear_bundle();
        serve("b3.s0", 32'h0000_0010, 4'b1111, 1'b1, 32'hDEAD_BEEF, 2, 32'h0);
        check_wb("b3.s0", 1'b0, 6'd0, 32'h0);
        tick();
        serve("b3.s1", 32'h0000_0020, 4'b1100, 1'b0, 32'h0, 2, 32'h8001_1234);
        check_wb("b3.s1", 1'b1, 6'd5, 32'h0000_8001);
        tick();
        serve("b3.s2", 32'h0000_0030, 4'b1000, 1'b1, 32'h5A5A_5A5A, 2, 32'h0);
        check_eq("b3.gap_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("b3.end_busy", {31'd0, busy}, 32'd0);

        // ---- unsigned byte + misaligned word loads ----
        set_slot(0, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0201, 32'h0, 6'd1);
        set_slot(1, 1'b1, 1'b0, 1'b1, 2'd3, 32'h0000_0207, 32'h0, 6'd2);
        issue_valid = 1'b1;
        tick();
        clear_bundle();
        serve("ub", 32'h0000_0200, 4'b0010, 1'b0, 32'h0, 1, 32'h0000_A500);
        check_wb("ub", 1'b1, 6'd1, 32'h0000_00A5);
        tick();
        serve("mw", 32'h0000_0204, 4'b1111, 1'b0, 32'h0, 1, 32'h8765_4321);
        check_wb("mw", 1'b1, 6'd2, 32'h8765_4321);
        tick();
        check_eq("mw.end_busy", {31'd0, busy}, 32'd0);

        // ---- load+store on one slot: a single store, no writeback ----
        set_slot(2, 1'b1, 1'b1, 1'b0, 2'd2, 32'h0000_0044, 32'hCAFE_F00D, 6'd9);
        issue_valid = 1'b1;
        tick();
        clear_bundle();
        serve("ls", 32'h0000_0044, 4'b1111, 1'b1, 32'hCAFE_F00D, 1, 32'h0);
        check_wb("ls", 1'b0, 6'd0, 32'h0);
        tick();
        check_eq("ls.end_busy", {31'd0, busy}, 32'd0);
        check_wb("ls.end", 1'b0, 6'd0, 32'h0);

        // ---- flush during slot0 REQ: slot0 finishes, slots 1/2 dropped ----
        set_slot(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0080, 32'h0, 6'd3);
        set_slot(1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0084, 32'h0, 6'd4);
        set_slot(2, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0088, 32'h0, 6'd0);
        issue_valid = 1'b1;
        tick();
        clear_bundle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        serve("fl", 32'h0000_0080, 4'b1111, 1'b0, 32'h0, 1, 32'h1122_3344);
        check_wb("fl", 1'b1, 6'd3, 32'h1122_3344);
        check_eq("fl.gap_busy", {31'd0, busy}, 32'd1);
        tick();
        check_eq("fl.end_busy", {31'd0, busy}, 32'd0);
        tick();
        check_eq("fl.no_req", {31'd0, mem_if.mem_req}, 32'd0);

        // ---- issue while busy: ignored, overrun sticky ----
        check_eq("ov.before", {31'd0, overrun}, 32'd0);
        set_slot(0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0040, 32'h0102_0304, 6'd0);
        issue_valid = 1'b1;
        tick();
        clear_bundle();
        set_slot(1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0050, 32'h0, 6'd7);
        issue_valid = 1'b1;
        tick();
        clear_bundle();
        check_eq("ov.flag", {31'd0, overrun}, 32'd1);
        serve("ov", 32'h0000_0040, 4'b1111, 1'b1, 32'h0102_0304, 1, 32'h0);
        tick();
        check_eq("ov.end_busy", {31'd0, busy}, 32'd0);
        check_eq("ov.no_req",   {31'd0, mem_if.mem_req}, 32'd0);

        // ---- empty bundle, and flush coinciding with issue in IDLE ----
        issue_valid = 1'b1;
        tick();
        clear_bundle();
        check_eq("empty.busy", {31'd0, busy}, 32'd0);
        check_eq("empty.ovr",  {31'd0, overrun}, 32'd1);
        set_slot(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0060, 32'h0, 6'd8);
        issue_valid = 1'b1;
        flush       = 1'b1;
        tick();
        clear_bundle();
        check_eq("fli.busy", {31'd0, busy}, 32'd0);
        check_eq("fli.req",  {31'd0, mem_if.mem_req}, 32'd0);

        // ---- reset in the middle of an access ----
        set_slot(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0070, 32'h0, 6'd10);
        issue_valid = 1'b1;
        tick();
        clear_bundle();
        check_eq("mrst.req_before", {31'd0, mem_if.mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mrst.req_async", {31'd0, mem_if.mem_req}, 32'd0);
        check_eq("mrst.busy",      {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check_wb("mrst", 1'b0, 6'd0, 32'h0);
        check_eq("mrst.ovr", {31'd0, overrun}, 32'd0);
        check_eq("mrst.end_busy", {31'd0, busy}, 32'd0);

`ifdef LSARB_TIMEOUT_EN
        // ---- watchdog: load never acked, abandoned after 255 REQ cycles ----
        set_slot(0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0000_0090, 32'h0,        6'd9);
        set_slot(1, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0000_0094, 32'h0BAD_F00D, 6'd0);
        issue_valid = 1'b1;
        tick();
        clear_bundle();
        repeat (254) tick();
        check_eq("tmo.still_req", {31'd0, mem_if.mem_req}, 32'd1);
        check_eq("tmo.no_err",    {31'd0, timeout_err}, 32'd0);
        tick();
        check_eq("tmo.req_low", {31'd0, mem_if.mem_req}, 32'd0);
        check_eq("tmo.err",     {31'd0, timeout_err}, 32'd1);
        check_wb("tmo", 1'b1, 6'd9, 32'hFFFF_FFFF);
        tick();
        serve("tmo.s1", 32'h0000_0094, 4'b1111, 1'b1, 32'h0BAD_F00D, 1, 32'h0);
        tick();
        check_eq("tmo.end_busy", {31'd0, busy}, 32'd0);
        check_eq("tmo.sticky",   {31'd0, timeout_err}, 32'd1);
`else
        check_eq("tmo.tied", {31'd0, timeout_err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vliw_lsu_arbiter.md
Name: vliw_lsu_arbiter

Overview:
Shares the single VLIW data-memory port between the three execution units. It captures the load/store requests of one issued bundle, serializes them in slot order (EU0, EU1, EU2) onto a req/ack memory interface, and returns load results as register writebacks. It sits between the eu0..eu2 load/store outputs and the vliw core's external bus logic. It drives the core stall through busy.

Parameters:
NUM_EU, 3, number of execution-unit slots arbitrated (fixed at 3 for this design)
REG_IDX_W, 6, width of a register index (64 registers)
TIMEOUT, 255, ack watchdog limit in cycles (used only with the optional feature)

Ports:
wb_clk_i  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  one-cycle strobe; bundle fields below are valid this cycle
flush  in  1  drop all not-yet-started accesses (branch/interrupt)
is_load  in  3  per-slot load request
is_store  in  3  per-slot store request
sign_extend  in  3  per-slot sign extension for loads
ls_size  in  6  per-slot size, 2 bits each: 0 byte, 1 half, 2 word, 3 word
ls_addr  in  96  per-slot byte address, 32 bits each, slot0 in bits 31:0
ls_wdata  in  96  per-slot store data, 32 bits each
ls_dest  in  3*REG_IDX_W  per-slot load destination register
busy  out  1  high while any captured access is pending or in flight
mem_req  out  1  memory request
mem_we  out  1  1 = store
mem_addr  out  32  word-aligned address (bits 1:0 forced 0)
mem_sel  out  4  byte enables
mem_wdata  out  32  store data replicated into lanes
mem_ack  in  1  access complete; mem_rdata valid the same cycle for loads
mem_rdata  in  32  aligned read word
wb_valid  out  1  one-cycle load writeback strobe
wb_idx  out  REG_IDX_W  writeback register
wb_val  out  32  writeback value
overrun  out  1  sticky: issue_valid seen while busy
timeout_err  out  1  sticky watchdog flag (see Optional Feature)

Behaviour:
- Reset, asynchronous: state IDLE, pending mask 0; busy, mem_req, mem_we, wb_valid, overrun, timeout_err = 0; mem_addr, mem_sel, mem_wdata, wb_idx, wb_val = 0.
- busy = (state != IDLE), combinational from state.
- IDLE, issue_valid=1: latch all slot fields; pending[i] = is_load[i] | is_store[i]. If both are set on a slot, the access is a store. If pending is 0, stay in IDLE.
- IDLE -> REQ when pending != 0. In REQ, mem_req=1 and fields of the lowest-index pending slot are driven from registers. The first mem_req is high the cycle after issue_valid.
- REQ holds mem_req and all fields stable until mem_ack=1 is sampled.
- On the ack edge:
  - clear that pending bit.
  - Load: wb_valid=1 next cycle for exactly one cycle, with wb_idx=dest and wb_val=extracted data.
  - Go to GAP. mem_req is low for exactly one cycle.
- GAP -> REQ if pending != 0, else IDLE.
- Byte lane selection: lane = addr[1:0] for byte, {addr[1],0} for half. mem_sel = 0001<<lane for byte, 0011<<lane for half, 1111 for word.
- Store data: mem_wdata = byte replicated x4, half replicated x2, or the full word.
- Load data extraction: data = mem_rdata >> (8*lane), truncated to the access size, then zero- or sign-extended per sign_extend.
- Misaligned half/word accesses: low address bits are ignored (aligned down).
- flush=1: clears every pending bit not currently in REQ. An in-flight REQ completes normally, including its writeback. flush in IDLE has no effect. If flush and issue_valid are high in the same cycle in IDLE, the bundle is discarded.
- issue_valid while busy: ignored, overrun set to 1 (cleared only by reset).
- Reset mid-access: mem_req drops immediately (asynchronous); no writeback is produced.

Optional Feature:
LSARB_TIMEOUT_EN
- Defined: a counter runs in REQ. If mem_ack is absent for TIMEOUT consecutive cycles:
  - the access is abandoned and timeout_err set (sticky);
  - a load writes back 0xFFFFFFFF to its destination;
  - then proceed as if acked.
- Undefined: REQ waits indefinitely; timeout_err tied 0.

Test Plan:
- Single load: slot1 byte, addr 0x103, sign_extend=1, rdata 0x80112233 -> mem_addr 0x100, mem_sel 1000, wb_val 0xFFFFFF80 to ls_dest[1] one cycle after ack.
- Three-slot bundle, slot0 store word 0xDEADBEEF @0x10, slot1 load half @0x22, slot2 store byte 0x5A @0x33; ack after 2 cycles each -> order 0,1,2; mem_req low one cycle between; mem_wdata 0x5A5A5A5A with mem_sel 1000 on the third; busy falls after the third ack.
- Slot with both is_load and is_store -> single store issued, no wb_valid.
- flush asserted during slot0's REQ in a three-slot bundle -> slot0 completes; slots 1 and 2 never issued; busy low after the GAP.
- issue_valid during busy -> ignored, overrun=1; empty bundle (all zero) -> busy stays 0.
- With LSARB_TIMEOUT_EN, TIMEOUT=255: load, mem_ack never asserted -> after 255 REQ cycles wb_val 0xFFFFFFFF, timeout_err=1, next slot proceeds.
